// File: rtl/sw_pixel_fetch.sv
// Search-window pixel fetcher: reads a SW_W x SW_H window from frame SRAM in raster order.
// Streams pixels over valid/ready. A 1-entry skid buffer absorbs the read that is in flight when the output stalls.
module sw_pixel_fetch #(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 12,
  parameter int FRAME_W = 64,
  parameter int SW_W    = 19,
  parameter int SW_H    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_x,
  input  logic [AWIDTH-1:0] base_y,
  output logic              busy,
  output logic              done,
  output logic              mem_ren,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DWIDTH-1:0] pix_data,
  output logic              pix_eol,
  output logic              pix_last
);

  localparam int CW = (SW_W > 1) ? $clog2(SW_W) : 1;
  localparam int RW = (SW_H > 1) ? $clog2(SW_H) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] base_x_q, base_x_d;
  logic [AWIDTH-1:0] base_y_q, base_y_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              rd_pend_q, rd_pend_d;
  logic              rd_eol_q, rd_eol_d;
  logic              rd_last_q, rd_last_d;

  logic              skid_vld_q, skid_vld_d;
  logic [DWIDTH-1:0] skid_dat_q, skid_dat_d;
  logic              skid_eol_q, skid_eol_d;
  logic              skid_last_q, skid_last_d;

  logic              pix_valid_q, pix_valid_d;
  logic [DWIDTH-1:0] pix_data_q, pix_data_d;
  logic              pix_eol_q, pix_eol_d;
  logic              pix_last_q, pix_last_d;

  logic issue;
  logic col_end;
  logic row_end;
  logic out_free;

  // Never issue when the returning word could find both output and skid occupied.
  assign issue    = (state_q == S_FETCH) && !skid_vld_q &&
                    !(rd_pend_q && pix_valid_q && !pix_ready);
  assign col_end  = (col_q == CW'(SW_W - 1));
  assign row_end  = (row_q == RW'(SW_H - 1));
  assign out_free = !pix_valid_q || pix_ready;

  assign mem_ren  = issue;
  assign mem_addr = (base_y_q + AWIDTH'(row_q)) * AWIDTH'(FRAME_W) + base_x_q + AWIDTH'(col_q);

  assign busy      = busy_q;
  assign done      = done_q;
  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign pix_eol   = pix_eol_q;
  assign pix_last  = pix_last_q;

  always_comb begin
    state_d     = state_q;
    base_x_d    = base_x_q;
    base_y_d    = base_y_q;
    col_d       = col_q;
    row_d       = row_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_pend_d   = issue;
    rd_eol_d    = col_end;
    rd_last_d   = col_end && row_end;
    skid_vld_d  = skid_vld_q;
    skid_dat_d  = skid_dat_q;
    skid_eol_d  = skid_eol_q;
    skid_last_d = skid_last_q;
    pix_valid_d = pix_valid_q;
    pix_data_d  = pix_data_q;
    pix_eol_d   = pix_eol_q;
    pix_last_d  = pix_last_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          base_x_d = base_x;
          base_y_d = base_y;
          col_d    = '0;
          row_d    = '0;
          busy_d   = 1'b1;
        end
      end
      S_FETCH: begin
        if (issue) begin
          if (col_end) begin
            col_d = '0;
            if (row_end) begin
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (pix_valid_q && pix_ready && pix_last_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      // One-cycle hold so a start coinciding with done is not accepted.
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (out_free) begin
      if (skid_vld_q) begin
        pix_valid_d = 1'b1;
        pix_data_d  = skid_dat_q;
        pix_eol_d   = skid_eol_q;
        pix_last_d  = skid_last_q;
        skid_vld_d  = 1'b0;
      end else if (rd_pend_q) begin
        pix_valid_d = 1'b1;
        pix_data_d  = mem_rdata;
        pix_eol_d   = rd_eol_q;
        pix_last_d  = rd_last_q;
      end else begin
        pix_valid_d = 1'b0;
        pix_eol_d   = 1'b0;
        pix_last_d  = 1'b0;
      end
    end else if (rd_pend_q) begin
      skid_vld_d  = 1'b1;
      skid_dat_d  = mem_rdata;
      skid_eol_d  = rd_eol_q;
      skid_last_d = rd_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_x_q    <= '0;
      base_y_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_eol_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_dat_q  <= '0;
      skid_eol_q  <= 1'b0;
      skid_last_q <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_eol_q   <= 1'b0;
      pix_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_x_q    <= base_x_d;
      base_y_q    <= base_y_d;
      col_q       <= col_d;
      row_q       <= row_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_pend_q   <= rd_pend_d;
      rd_eol_q    <= rd_eol_d;
      rd_last_q   <= rd_last_d;
      skid_vld_q  <= skid_vld_d;
      skid_dat_q  <= skid_dat_d;
      skid_eol_q  <= skid_eol_d;
      skid_last_q <= skid_last_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_eol_q   <= pix_eol_d;
      pix_last_q  <= pix_last_d;
    end
  end

endmodule
